// File: rtl/ram_6r1w_wr_arbiter.sv
// Round-robin write-port scheduler for the 16-entry 6R1W register RAM.
// One grant per cycle feeds a one-deep commit stage; a scoreboard tracks written entries.

module ram_6r1w_wr_arbiter_lane #(
  parameter int NREQ = 4,
  parameter int IDX  = 0,
  parameter int RRW  = 2
) (
  input  logic [RRW-1:0]  rr,
  input  logic [NREQ-1:0] valid,
  output logic            gnt
);
  // Requester IDX wins when valid and no valid requester sits closer to rr in search order.
  always_comb begin
    int di;
    int dj;
    gnt = valid[IDX];
    di  = (IDX + NREQ - int'(rr)) % NREQ;
    dj  = 0;
    for (int j = 0; j < NREQ; j++) begin
      dj = (j + NREQ - int'(rr)) % NREQ;
      if (valid[j] && (dj < di)) gnt = 1'b0;
    end
  end
endmodule

module ram_6r1w_wr_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*4-1:0]     req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic [3:0]            ram_addrw,
  output logic [WIDTH-1:0]      ram_din,
  output logic                  ram_wea,
  output logic                  fwd_valid,
  output logic [3:0]            fwd_addr,
  output logic [WIDTH-1:0]      fwd_data,
  output logic [15:0]           entry_valid
);
  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [RRW-1:0]   rr, rr_nxt;
  logic [NREQ-1:0]  gnt_raw;
  logic             gnt_en, any_gnt;
  logic [3:0]       win_addr;
  logic [WIDTH-1:0] win_data;
  logic             stg_v;
  logic [3:0]       stg_addr;
  logic [WIDTH-1:0] stg_data;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_lane
      ram_6r1w_wr_arbiter_lane #(.NREQ(NREQ), .IDX(g), .RRW(RRW)) u_lane (
        .rr    (rr),
        .valid (req_valid),
        .gnt   (gnt_raw[g])
      );
    end
  endgenerate

  // rst_n gates grants combinationally so nothing handshakes while reset is held.
  assign gnt_en    = rst_n & ~stall & ~flush;
  assign req_ready = gnt_raw & {NREQ{gnt_en}};
  assign any_gnt   = |req_ready;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    rr_nxt   = rr;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win_addr = req_addr[4*i +: 4];
        win_data = req_data[WIDTH*i +: WIDTH];
        rr_nxt   = (i == NREQ-1) ? '0 : RRW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= '0;
      stg_v    <= 1'b0;
      stg_addr <= '0;
      stg_data <= '0;
    end else begin
      rr    <= rr_nxt;
      stg_v <= any_gnt;
      if (any_gnt) begin
        stg_addr <= win_addr;
        stg_data <= win_data;
      end
    end
  end

  // Flush cancels the staged write, so it never reaches the RAM or the scoreboard.
  assign ram_wea   = stg_v & ~flush;
  assign ram_addrw = stg_addr;
  assign ram_din   = stg_data;
  assign fwd_valid = ram_wea;
  assign fwd_addr  = stg_addr;
  assign fwd_data  = stg_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       entry_valid <= '0;
    else if (flush)   entry_valid <= '0;
    else if (ram_wea) entry_valid[ram_addrw] <= 1'b1;
  end
endmodule

// File: tb/tb_ram_6r1w_wr_arbiter.sv
// Directed bench for ram_6r1w_wr_arbiter: reset, single write, round-robin, stall, flush, async reset.
`timescale 1ns/1ps
module tb_ram_6r1w_wr_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*4-1:0]     req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  stall, flush;
  logic [3:0]            ram_addrw, fwd_addr;
  logic [WIDTH-1:0]      ram_din, fwd_data;
  logic                  ram_wea, fwd_valid;
  logic [15:0]           entry_valid;

  int checks = 0;
  int errors = 0;

  ram_6r1w_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .stall(stall), .flush(flush),
    .ram_addrw(ram_addrw), .ram_din(ram_din), .ram_wea(ram_wea),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .entry_valid(entry_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [WIDTH-1:0] d);
    req_valid[i]              = v;
    req_addr[4*i +: 4]        = a;
    req_data[WIDTH*i +: WIDTH] = d;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, 64'(req_ready), 64'h0);
    chk({tag, ".wea"},   64'(ram_wea),   64'h0);
    chk({tag, ".fwdv"},  64'(fwd_valid), 64'h0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; stall = 1'b0; flush = 1'b0;

    // Reset then idle
    repeat (3) begin
      tick(); #1;
      chk_idle("rst");
    end
    tick(); rst_n = 1'b1;
    repeat (5) begin
      #1;
      chk_idle("idle");
      chk("idle.addrw", 64'(ram_addrw),   64'h0);
      chk("idle.din",   64'(ram_din),     64'h0);
      chk("idle.ev",    64'(entry_valid), 64'h0);
      tick();
    end

    // Single write: requester 2, addr 5
    set_req(2, 1'b1, 4'd5, 32'hDEADBEEF); #1;
    chk("single.ready", 64'(req_ready), 64'h4);
    tick(); set_req(2, 1'b0, 4'd0, 32'h0); #1;
    chk("single.wea",   64'(ram_wea),   64'h1);
    chk("single.addrw", 64'(ram_addrw), 64'h5);
    chk("single.din",   64'(ram_din),   64'hDEADBEEF);
    chk("single.fwdv",  64'(fwd_valid), 64'h1);
    chk("single.fwda",  64'(fwd_addr),  64'h5);
    chk("single.fwdd",  64'(fwd_data),  64'hDEADBEEF);
    chk("single.ev0",   64'(entry_valid), 64'h0);
    tick(); #1;
    chk("single.ev",    64'(entry_valid), 64'h0020);
    chk("single.wea0",  64'(ram_wea),     64'h0);

    // Fresh reset so the pointer starts at 0 for the fairness run
    tick(); rst_n = 1'b0; #1;
    chk("rr.rstev", 64'(entry_valid), 64'h0);
    tick(); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4'(i), 32'h100 + 32'(i));
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr.gnt%0d", k), 64'(req_ready), 64'(4'b1 << (k % 4)));
      if (k > 0) begin
        chk($sformatf("rr.wea%0d", k),  64'(ram_wea),   64'h1);
        chk($sformatf("rr.addr%0d", k), 64'(ram_addrw), 64'((k - 1) % 4));
        chk($sformatf("rr.din%0d", k),  64'(ram_din),   64'(32'h100 + 32'((k - 1) % 4)));
      end
      tick();
    end
    req_valid = '0; #1;
    chk("rr.wea8",  64'(ram_wea),   64'h1);
    chk("rr.addr8", 64'(ram_addrw), 64'h3);
    tick(); #1;
    chk("rr.ev",    64'(entry_valid), 64'h000F);
    chk("rr.wea9",  64'(ram_wea),     64'h0);

    // Stall: requesters 0 and 1 wait two cycles
    tick();
    set_req(0, 1'b1, 4'd10, 32'hA0A0);
    set_req(1, 1'b1, 4'd11, 32'hB1B1);
    stall = 1'b1;
    repeat (2) begin
      #1; chk_idle("stall");
      tick();
    end
    stall = 1'b0; #1;
    chk("stall.rel.ready", 64'(req_ready), 64'h1);
    chk("stall.rel.wea",   64'(ram_wea),   64'h0);
    tick(); req_valid[0] = 1'b0; #1;
    chk("stall.g1.ready",  64'(req_ready), 64'h2);
    chk("stall.g1.wea",    64'(ram_wea),   64'h1);
    chk("stall.g1.addr",   64'(ram_addrw), 64'd10);
    chk("stall.g1.din",    64'(ram_din),   64'hA0A0);
    tick(); req_valid[1] = 1'b0; #1;
    chk("stall.g2.wea",    64'(ram_wea),   64'h1);
    chk("stall.g2.addr",   64'(ram_addrw), 64'd11);
    chk("stall.g2.din",    64'(ram_din),   64'hB1B1);
    tick(); #1;
    chk("stall.ev",        64'(entry_valid), 64'h0C0F);

    // Flush collision: requester 3 to addr 9, flush in its commit cycle
    tick(); set_req(3, 1'b1, 4'd9, 32'h9999); #1;
    chk("flush.gnt", 64'(req_ready), 64'h8);
    tick(); req_valid[3] = 1'b0; set_req(0, 1'b1, 4'd1, 32'h1111); flush = 1'b1; #1;
    chk_idle("flush");
    tick(); flush = 1'b0; #1;
    chk("flush.ev",     64'(entry_valid), 64'h0);
    chk("flush.wea",    64'(ram_wea),     64'h0);
    chk("flush.resume", 64'(req_ready),   64'h1);
    tick(); req_valid[0] = 1'b0; #1;
    chk("flush.wea2",   64'(ram_wea),     64'h1);
    chk("flush.addr2",  64'(ram_addrw),   64'd1);
    tick(); #1;
    chk("flush.ev2",    64'(entry_valid), 64'h0002);

    // Async reset mid-stream while requester 1 (addr 7) is staged
    tick(); set_req(1, 1'b1, 4'd7, 32'h7777); #1;
    chk("areset.gnt", 64'(req_ready), 64'h2);
    tick(); req_valid[1] = 1'b0; #1;
    chk("areset.wea1", 64'(ram_wea), 64'h1);
    #1 rst_n = 1'b0; #1;
    chk("areset.wea0", 64'(ram_wea),     64'h0);
    chk("areset.ev0",  64'(entry_valid), 64'h0);
    req_valid = '1; #1;
    chk("areset.noready", 64'(req_ready), 64'h0);
    tick(); rst_n = 1'b1; #1;
    chk("areset.ev",   64'(entry_valid), 64'h0);
    chk("areset.rr",   64'(req_ready),   64'h1);
    chk("areset.wea",  64'(ram_wea),     64'h0);
    tick(); req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
